// File: rtl/mux_pkg.sv
// Shared defaults for the pipelined N-to-1 mux family.
// MUX_RR_EN (optional) selects round-robin arbitration instead of explicit sel.
`ifndef MUX_SEL_W
`define MUX_SEL_W(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package mux_pkg;

    localparam int unsigned DATA_BITS  = 16;
    localparam int unsigned MUX_DATA_W = DATA_BITS;
    localparam int unsigned MUX_N_CH   = 4;

    // Every bit of out_data takes this value on reset.
    localparam logic OUT_DATA_RST_BIT = 1'b0;

endpackage

// File: rtl/mux_nto1_pipe_rr_arbiter.sv
// Round-robin grant among valid requesters, searching upward from a pointer.
// Only built when MUX_RR_EN is defined.
`ifdef MUX_RR_EN
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned N_CH  = MUX_N_CH,
    parameter int unsigned SEL_W = `MUX_SEL_W(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic             advance,
    output logic [SEL_W-1:0] grant,
    output logic             grant_valid
);

    logic [SEL_W-1:0] ptr;

    always_comb begin
        grant       = ptr;
        grant_valid = 1'b0;
        for (int unsigned off = 0; off < N_CH; off++) begin
            if (!grant_valid && req[SEL_W'((32'(ptr) + off) % N_CH)]) begin
                grant       = SEL_W'((32'(ptr) + off) % N_CH);
                grant_valid = 1'b1;
            end
        end
    end

    // Pointer moves past the winner only when its word is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && grant_valid) begin
            ptr <= SEL_W'((32'(grant) + 32'd1) % N_CH);
        end
    end

endmodule
`endif

// File: rtl/mux_nto1_pipe.sv
// N-channel mux with one registered output stage and valid/ready on every side.
// Define MUX_RR_EN for round-robin selection among valid channels (sel ignored).
module mux_nto1_pipe
    import mux_pkg::*;
#(
    parameter int unsigned DATA_W = MUX_DATA_W,
    parameter int unsigned N_CH   = MUX_N_CH,
    parameter int unsigned SEL_W  = `MUX_SEL_W(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic [SEL_W-1:0]       sel,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SEL_W-1:0]       grant_ch,
    output logic                   sel_err
);

    logic [SEL_W-1:0]  g;
    logic              g_ok;
    logic              load;
    logic              xfer;
    logic [DATA_W-1:0] g_data;

`ifdef MUX_RR_EN
    logic unused_sel;
    assign unused_sel = ^sel;
    assign sel_err    = 1'b0;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (in_valid),
        .advance     (xfer),
        .grant       (g),
        .grant_valid (g_ok)
    );
`else
    logic sel_err_q;

    assign g       = sel;
    assign g_ok    = ({1'b0, sel} < (SEL_W+1)'(N_CH));
    assign sel_err = sel_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= !g_ok;
        end
    end
`endif

    assign load = !out_valid || out_ready;

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        in_ready = '0;
        g_data   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (g == SEL_W'(i)) begin
                in_ready[i] = rst_n && load && g_ok;
                g_data      = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer = |(in_ready & in_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= {DATA_W{OUT_DATA_RST_BIT}};
            grant_ch  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= g_data;
            grant_ch  <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: N_CH=4 and N_CH=3 instances checked against a behavioural model.
// Directed tests follow the build mode (MUX_RR_EN defined or not).
module tb_mux_nto1_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [63:0] d4;
    logic [3:0]  v4, r4;
    logic [1:0]  s4, g4;
    logic [15:0] o4;
    logic        ov4, or4, e4;

    logic [47:0] d3;
    logic [2:0]  v3, r3;
    logic [1:0]  s3, g3;
    logic [15:0] o3;
    logic        ov3, or3, e3;

    mux_nto1_pipe #(.DATA_W(16), .N_CH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_ready(r4),
        .sel(s4), .out_data(o4), .out_valid(ov4), .out_ready(or4),
        .grant_ch(g4), .sel_err(e4)
    );

    mux_nto1_pipe #(.DATA_W(16), .N_CH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_ready(r3),
        .sel(s3), .out_data(o3), .out_valid(ov3), .out_ready(or3),
        .grant_ch(g3), .sel_err(e3)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    typedef struct {
        bit v;
        int d;
        int g;
        bit err;
        int ptr;
    } mdl_t;

    mdl_t m4, m3;

    // Channel that would be served this cycle, or -1 if none.
    function automatic int pick(mdl_t m, int n, int sel, int valid);
`ifdef MUX_RR_EN
        for (int off = 0; off < n; off++) begin
            int c = (m.ptr + off) % n;
            if (((valid >> c) & 1) != 0) return c;
        end
        return -1;
`else
        return (sel < n) ? sel : -1;
`endif
    endfunction

    function automatic int exp_ready(mdl_t m, int n, int sel, int valid, bit orr, bit rstn);
        int g = pick(m, n, sel, valid);
        if (!rstn || g < 0 || (m.v && !orr)) return 0;
        return 1 << g;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int n, int sel, int valid, logic [63:0] data, bit orr);
        mdl_t nm = m;
        int g = pick(m, n, sel, valid);
        int r = exp_ready(m, n, sel, valid, orr, 1'b1);
`ifdef MUX_RR_EN
        nm.err = 1'b0;
`else
        nm.err = (sel >= n);
`endif
        if (r != 0 && ((valid >> g) & 1) != 0) begin
            nm.v   = 1'b1;
            nm.d   = int'((data >> (16 * g)) & 64'hFFFF);
            nm.g   = g;
            nm.ptr = (g + 1) % n;
        end else if (orr) begin
            nm.v = 1'b0;
        end
        return nm;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4 = '{default: 0};
            m3 = '{default: 0};
        end else begin
            m4 = mstep(m4, 4, int'(s4), int'(v4), d4, or4);
            m3 = mstep(m3, 3, int'(s3), int'(v3), {16'h0, d3}, or3);
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("m4_out_valid", 32'(ov4), 32'(m4.v));
            if (m4.v) begin
                check("m4_out_data", 32'(o4), m4.d);
                check("m4_grant_ch", 32'(g4), m4.g);
            end
            check("m4_sel_err", 32'(e4), 32'(m4.err));
            check("m4_in_ready", 32'(r4), exp_ready(m4, 4, int'(s4), int'(v4), or4, rst_n));
            check("m3_out_valid", 32'(ov3), 32'(m3.v));
            if (m3.v) begin
                check("m3_out_data", 32'(o3), m3.d);
                check("m3_grant_ch", 32'(g3), m3.g);
            end
            check("m3_sel_err", 32'(e3), 32'(m3.err));
            check("m3_in_ready", 32'(r3), exp_ready(m3, 3, int'(s3), int'(v3), or3, rst_n));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        d4 = '0; v4 = '0; s4 = '0; or4 = 1'b0;
        d3 = '0; v3 = '0; s3 = '0; or3 = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(ov4), 0);
        check("rst_out_data", 32'(o4), 0);
        check("rst_grant_ch", 32'(g4), 0);
        check("rst_sel_err", 32'(e4), 0);
        check("rst_in_ready", 32'(r4), 0);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        tick();

`ifndef MUX_RR_EN
        // single transfer on ch2
        s4 = 2'd2; v4 = 4'b0100; d4[32 +: 16] = 16'hA5A5; or4 = 1'b1;
        #1 check("t1_in_ready", 32'(r4), 32'b0100);
        tick();
        check("t1_out_valid", 32'(ov4), 1);
        check("t1_out_data", 32'(o4), 32'hA5A5);
        check("t1_grant_ch", 32'(g4), 2);
        v4 = '0;

        // stall with ch0 word held
        s4 = 2'd0; v4 = 4'b0001; d4[0 +: 16] = 16'h1111;
        tick();
        check("t2_load", 32'(o4), 32'h1111);
        or4 = 1'b0; s4 = 2'd1; v4 = 4'b1111; d4[16 +: 16] = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            #1 check("t2_stall_ready", 32'(r4), 0);
            tick();
            check("t2_stall_data", 32'(o4), 32'h1111);
            check("t2_stall_grant", 32'(g4), 0);
        end
        or4 = 1'b1;
        #1 check("t2_release_ready", 32'(r4), 32'b0010);
        tick();
        check("t2_release_data", 32'(o4), 32'h2222);
        check("t2_release_grant", 32'(g4), 1);
        v4 = '0;

        // back-to-back stream from ch3
        s4 = 2'd3;
        for (int k = 1; k <= 4; k++) begin
            d4[48 +: 16] = 16'(k);
            v4 = 4'b1000;
            tick();
            check("t3_stream_valid", 32'(ov4), 1);
            check("t3_stream_data", 32'(o4), k);
        end
        v4 = '0;
        tick();
        check("t3_drained", 32'(ov4), 0);

        // N_CH=3: normal load, then sel out of range
        s3 = 2'd2; v3 = 3'b100; d3[32 +: 16] = 16'h0BEE; or3 = 1'b1;
        tick();
        check("t4_load_data", 32'(o3), 32'h0BEE);
        check("t4_load_grant", 32'(g3), 2);
        or3 = 1'b0; v3 = '0; s3 = 2'd3;
        #1 check("t4_bad_ready", 32'(r3), 0);
        tick();
        check("t4_err_pulse", 32'(e3), 1);
        check("t4_held_valid", 32'(ov3), 1);
        or3 = 1'b1;
        tick();
        check("t4_err_held", 32'(e3), 1);
        check("t4_drained", 32'(ov3), 0);
        s3 = 2'd0;
        tick();
        check("t4_err_clear", 32'(e3), 0);
        s3 = 2'd3;
        tick();
        s3 = 2'd0;
        check("t4_one_pulse", 32'(e3), 1);
        tick();
        check("t4_one_clear", 32'(e3), 0);

        // asynchronous reset during a stall
        s4 = 2'd0; v4 = 4'b0001; d4[0 +: 16] = 16'h1234; or4 = 1'b1;
        tick();
        or4 = 1'b0; v4 = '0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(ov4), 0);
        check("t5_rst_data", 32'(o4), 0);
        check("t5_rst_ready", 32'(r4), 0);
        tick();
        rst_n = 1'b1;
        s4 = 2'd1; v4 = 4'b0010; d4[16 +: 16] = 16'h5678; or4 = 1'b1;
        tick();
        check("t5_after_data", 32'(o4), 32'h5678);
        check("t5_after_grant", 32'(g4), 1);
        v4 = '0;
        tick();
`else
        begin
            int seq_a[5] = '{0, 1, 2, 3, 0};
            int seq_b[3] = '{1, 3, 1};
            for (int c = 0; c < 4; c++) d4[c*16 +: 16] = 16'(16'hC000 + c);
            or4 = 1'b1;
            v4  = 4'b1111;
            for (int i = 0; i < 5; i++) begin
                tick();
                check("rr_all_grant", 32'(g4), seq_a[i]);
                check("rr_all_data", 32'(o4), 32'hC000 + seq_a[i]);
            end
            v4 = 4'b1010;
            for (int i = 0; i < 3; i++) begin
                tick();
                check("rr_sparse_grant", 32'(g4), seq_b[i]);
            end
            v4 = '0;
            tick();
            check("rr_idle", 32'(ov4), 0);
        end
`endif

        tick();
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mux_nto1_pipe.md
Name: mux_nto1_pipe

Overview:
- Parametrised N-channel, DATA_W-bit multiplexer with one registered output stage and valid/ready handshakes on every input channel and on the output.
- Successor to the team's combinational 2-to-1 data-path muxes.
- Sits between several producers (ALU/load/forwarding paths) and one consumer stage that may stall.
- Selection is either explicit via `sel` or, with the optional feature, round-robin among valid channels.

Parameters:
- DATA_W, 16, data width per channel; matches the project DATA_BITS.
- N_CH, 4, number of input channels; N_CH >= 2.
- SEL_W, $clog2(N_CH), width of `sel` and `grant_ch`.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  N_CH  channel i holds valid data.
- in_ready  out  N_CH  channel i transfer accepted this cycle when in_valid[i] && in_ready[i].
- sel  in  SEL_W  explicit channel select; ignored when MUX_RR_EN is defined.
- out_data  out  DATA_W  registered output data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- grant_ch  out  SEL_W  registered index of the channel that supplied out_data.
- sel_err  out  1  registered one-cycle pulse: an out-of-range `sel` was presented.

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, out_data=0, grant_ch=0, sel_err=0, RR pointer=0.
  - in_ready is all-zero while rst_n is low.
- Effective channel `g`: `sel` in explicit mode; the arbiter grant in RR mode.
- Define load = !out_valid || out_ready.
- in_ready[i] = load && (i == g) && (g < N_CH). Every other bit is 0. At most one bit of in_ready is ever 1.
- Transfer on channel g (in_valid[g] && in_ready[g]) at edge k:
  - out_data <= in_data[g], grant_ch <= g, out_valid <= 1, all visible after edge k.
  - Latency is 1 cycle.
  - Throughput is 1 word/cycle while out_ready=1.
- No transfer and out_ready=1: out_valid <= 0.
- Stall (out_valid=1, out_ready=0): out_data and grant_ch stay frozen and in_ready is all-zero, regardless of changes on sel or in_valid.
- Simultaneous drain and load (out_valid=1, out_ready=1, new transfer): the register is overwritten in the same edge and out_valid stays 1.
- in_valid[g]=0: no transfer. Valid data on non-selected channels is never consumed.
- sel >= N_CH (only possible when N_CH is not a power of two):
  - No grant is issued and in_ready is all-zero.
  - sel_err <= 1 for the next cycle only; it is re-evaluated every cycle.
  - Any current output is still drained normally.
- Reset asserted mid-stall: the held word is discarded and out_valid drops asynchronously.

Optional Feature:
- Macro: MUX_RR_EN.
- When defined:
  - `sel` is ignored and sel_err is tied to 0.
  - g = the first channel with in_valid set, searching from the RR pointer upward with wrap-around modulo N_CH.
  - The pointer <= g+1 (mod N_CH) only on a transfer. It is unchanged during stalls or when no channel is valid.
  - Starvation-free: a continuously valid channel is granted within N_CH transfers.
- When undefined: explicit-select mode as above, and no arbiter logic is instantiated.

Decomposition:
- Shared package mux_pkg:
  - default DATA_W (aliasing DATA_BITS) and N_CH;
  - the SEL_W derivation macro;
  - a reset-value constant for out_data.
- One natural sub-module, rr_arbiter: N_CH request vector, pointer register, grant index plus grant_valid, advance input. Compiled only under MUX_RR_EN.
- The output register and handshake stay in mux_nto1_pipe.

Test Plan:
- Explicit mode, N_CH=4, sel=2, in_valid=4'b0100, in_data ch2=16'hA5A5, out_ready=1 -> in_ready=4'b0100; one cycle later out_valid=1, out_data=16'hA5A5, grant_ch=2.
- Stall: out_valid=1 with 16'h1111 from ch0, out_ready=0 for 3 cycles while sel switches to 1 and in_valid=4'b1111 -> in_ready=0, out_data stays 16'h1111; when out_ready=1, ch1 loads on that edge.
- Back-to-back: sel=3, ch3 presents 16'h0001..16'h0004 with out_ready=1 -> four consecutive output cycles, no bubbles, order preserved.
- N_CH=3, sel=3 -> in_ready=3'b000, sel_err pulses 1 for exactly one cycle; with sel held, it pulses each cycle; with sel=0, it clears.
- Reset mid-stall: rst_n low asynchronously between edges -> out_valid=0, out_data=0 immediately; after release, the first transfer behaves normally.
- MUX_RR_EN, N_CH=4, in_valid=4'b1111 held, out_ready=1 -> grant_ch sequence 0,1,2,3,0; with in_valid=4'b1010 -> sequence 1,3,1.
